program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side counterpart to the pipeline observation harness: streams a program image into the CPU's instruction memory and data memory, then raises start.
- Sits between an off-chip/bench word stream (valid/ready) and the CPU memory write ports.
- Releases the CPU through start_o only after the whole image has been written.

Parameters:
IADDR_W, 8, instruction memory address width in words (depth 256)
DADDR_W, 5, data memory address width in bytes (32 bytes)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_data_i  in  32  stream word
in_valid_i  in  1  stream word valid
in_ready_o  out  1  loader can accept word this cycle
imem_we_o  out  1  instruction memory write enable
imem_addr_o  out  IADDR_W  instruction word index
imem_data_o  out  32  instruction word
dmem_we_o  out  1  data memory byte write enable
dmem_addr_o  out  DADDR_W  data byte address
dmem_data_o  out  8  data byte
start_o  out  1  CPU start, held high once load completes
err_o  out  1  sticky header/trailer error

Behaviour:
- Reset: rst_i sampled on clk_i rising edge; all outputs 0; state IDLE; counters 0. Reset mid-load aborts at once: no write strobe in the cycle after reset; start_o/err_o drop.
- Transfer occurs when in_valid_i && in_ready_o at the rising edge.
- States: IDLE, LOAD_I, LOAD_D, DRAIN_D, DONE, ERROR.
- IDLE: in_ready_o=1. Header word: NI=[31:16] (instruction words), ND=[15:0] (data words).
  - NI > 2^IADDR_W or 4*ND > 2^DADDR_W -> ERROR.
  - Else go to LOAD_I if NI>0, else LOAD_D if ND>0, else DONE.
- LOAD_I: in_ready_o=1.
  - Word k (k=0..NI-1) produces imem_we_o=1, imem_addr_o=k, imem_data_o=word in the cycle after the transfer (1-cycle registered latency).
  - Back-to-back transfers give one write per cycle.
  - After word NI-1: go to LOAD_D if ND>0, else DONE.
- LOAD_D: in_ready_o=1. Transfer of data word j latches the word and goes to DRAIN_D.
- DRAIN_D: in_ready_o=0. Four consecutive cycles drive dmem_we_o=1, dmem_addr_o=4j+b, dmem_data_o=word[8b+7:8b] for b=0..3, little-endian, so memory[4j+3..4j] reassembles the word.
  - After b=3: go to LOAD_D if j<ND-1, else DONE.
  - Throughput: one data word per 5 cycles minimum.
- Stalled source (in_valid_i=0) holds state; strobes are 0 while waiting.
- DONE: start_o=1 from the first DONE cycle, held until rst_i. in_ready_o=0; further stream words are ignored and cause no writes.
- ERROR: err_o=1, start_o=0, in_ready_o=0, no writes; exited only by rst_i.
- imem_we_o and dmem_we_o are never high in the same cycle. Address/data outputs hold their last values when the strobe is 0.
- Address arithmetic never wraps; header checks guarantee in-range addresses.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CHECK after the last payload word (or after the header if NI=ND=0).
  - Keeps a 32-bit modulo-2^32 sum of all payload words (instruction and data, excluding the header).
  - CHECK has in_ready_o=1 and takes one trailer word: equal to the sum -> DONE; otherwise -> ERROR.
  - All memory writes already issued remain.
- Undefined: no trailer word, no CHECK state, no sum logic; the last payload word leads directly to DONE.

Test Plan:
- Header 0x0002_0001, instr 0x2008_0005, 0x0000_0000, data 0x1122_3344, valid every cycle -> imem[0]=0x20080005, imem[1]=0; dmem bytes 0..3 = 44,33,22,11 on 4 consecutive cycles; start_o=1 in the cycle after the byte-3 write; err_o=0.
- Header 0x0000_0000 -> start_o=1 on the 2nd cycle after the header transfer; no write strobes.
- Header 0x0101_0000 (NI=257) -> err_o=1, in_ready_o=0, start_o stays 0 for 20 cycles; rst_i pulse clears err_o and returns to IDLE with in_ready_o=1.
- Header 0x0000_0009 (36 bytes > 32) -> ERROR. Header 0x0000_0008 with 8 data words -> last byte write at dmem_addr_o=31, then start_o=1.
- rst_i asserted during DRAIN_D byte 2 -> next cycle dmem_we_o=0, start_o=0. A fresh header loads normally afterwards.
- LOADER_CHECKSUM_EN: header 0x0001_0000, word 0x0000_0010, trailer 0x0000_0010 -> start_o=1. Repeat with trailer 0x0000_0011 -> err_o=1, start_o=0, imem[0]=0x10 still written.

Source files
------------

// File: rtl/program_loader.sv
// Streams a header-described program image into instruction and data memory, then raises start_o.
// Optional trailer checksum stage is built when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               imem_we_o,
    output logic [IADDR_W-1:0] imem_addr_o,
    output logic [31:0]        imem_data_o,
    output logic               dmem_we_o,
    output logic [DADDR_W-1:0] dmem_addr_o,
    output logic [7:0]         dmem_data_o,
    output logic               start_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        DRAIN_D,
        DONE,
        ERROR
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    localparam logic [31:0] IMEM_WORDS = 32'(1) << IADDR_W;
    localparam logic [31:0] DMEM_BYTES = 32'(1) << DADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHECK;
`else
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t             state_reg, state_next;
    logic [15:0]        ni_reg, ni_next;
    logic [15:0]        nd_reg, nd_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [1:0]         byte_reg, byte_next;
    logic [31:0]        word_reg, word_next;
    logic               imem_we_reg, imem_we_next;
    logic [IADDR_W-1:0] imem_addr_reg, imem_addr_next;
    logic [31:0]        imem_data_reg, imem_data_next;
    logic               dmem_we_reg, dmem_we_next;
    logic [DADDR_W-1:0] dmem_addr_reg, dmem_addr_next;
    logic [7:0]         dmem_data_reg, dmem_data_next;
    logic               start_reg, start_next;
    logic               err_reg, err_next;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]        sum_reg, sum_next;
`endif

    logic        ready;
    logic        xfer;
    logic [15:0] hdr_ni;
    logic [15:0] hdr_nd;
    logic        hdr_bad;
    logic [7:0]  lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign hdr_ni  = in_data_i[31:16];
    assign hdr_nd  = in_data_i[15:0];
    // Widen before scaling so a huge ND cannot alias back into range.
    assign hdr_bad = (32'(hdr_ni) > IMEM_WORDS) || ((32'(hdr_nd) << 2) > DMEM_BYTES);

    always_comb begin
        ready = 1'b0;
        case (state_reg)
            IDLE, LOAD_I, LOAD_D: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                ready = 1'b1;
`endif
            default:              ready = 1'b0;
        endcase
    end

    assign in_ready_o = ready && !rst_i;
    assign xfer       = in_valid_i && in_ready_o;

    always_comb begin
        state_next     = state_reg;
        ni_next        = ni_reg;
        nd_next        = nd_reg;
        cnt_next       = cnt_reg;
        byte_next      = byte_reg;
        word_next      = word_reg;
        imem_we_next   = 1'b0;
        imem_addr_next = imem_addr_reg;
        imem_data_next = imem_data_reg;
        dmem_we_next   = 1'b0;
        dmem_addr_next = dmem_addr_reg;
        dmem_data_next = dmem_data_reg;
`ifdef LOADER_CHECKSUM_EN
        sum_next       = sum_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    ni_next  = hdr_ni;
                    nd_next  = hdr_nd;
                    cnt_next = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_next = 32'd0;
`endif
                    if (hdr_bad)
                        state_next = ERROR;
                    else if (hdr_ni != 16'd0)
                        state_next = LOAD_I;
                    else if (hdr_nd != 16'd0)
                        state_next = LOAD_D;
                    else
                        state_next = AFTER_PAYLOAD;
                end
            end

            LOAD_I: begin
                if (xfer) begin
                    imem_we_next   = 1'b1;
                    imem_addr_next = cnt_reg[IADDR_W-1:0];
                    imem_data_next = in_data_i;
`ifdef LOADER_CHECKSUM_EN
                    sum_next       = sum_reg + in_data_i;
`endif
                    if (cnt_reg == ni_reg - 16'd1) begin
                        cnt_next   = 16'd0;
                        state_next = (nd_reg != 16'd0) ? LOAD_D : AFTER_PAYLOAD;
                    end else begin
                        cnt_next   = cnt_reg + 16'd1;
                    end
                end
            end

            LOAD_D: begin
                if (xfer) begin
                    word_next  = in_data_i;
                    byte_next  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_next   = sum_reg + in_data_i;
`endif
                    state_next = DRAIN_D;
                end
            end

            DRAIN_D: begin
                // Bytes leave least significant first so memory[4j+3..4j] rebuilds the word.
                dmem_we_next   = 1'b1;
                dmem_addr_next = {cnt_reg[DADDR_W-3:0], byte_reg};
                dmem_data_next = lane[byte_reg];
                byte_next      = byte_reg + 2'd1;
                if (byte_reg == 2'd3) begin
                    if (cnt_reg == nd_reg - 16'd1) begin
                        state_next = AFTER_PAYLOAD;
                    end else begin
                        cnt_next   = cnt_reg + 16'd1;
                        state_next = LOAD_D;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer)
                    state_next = (in_data_i == sum_reg) ? DONE : ERROR;
            end
`endif

            default: state_next = state_reg;
        endcase
    end

    // start_o follows the DONE state by one cycle so the last write always lands first.
    assign start_next = (state_reg == DONE);
    assign err_next   = (state_next == ERROR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ni_reg        <= '0;
            nd_reg        <= '0;
            cnt_reg       <= '0;
            byte_reg      <= '0;
            word_reg      <= '0;
            imem_we_reg   <= 1'b0;
            imem_addr_reg <= '0;
            imem_data_reg <= '0;
            dmem_we_reg   <= 1'b0;
            dmem_addr_reg <= '0;
            dmem_data_reg <= '0;
            start_reg     <= 1'b0;
            err_reg       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ni_reg        <= ni_next;
            nd_reg        <= nd_next;
            cnt_reg       <= cnt_next;
            byte_reg      <= byte_next;
            word_reg      <= word_next;
            imem_we_reg   <= imem_we_next;
            imem_addr_reg <= imem_addr_next;
            imem_data_reg <= imem_data_next;
            dmem_we_reg   <= dmem_we_next;
            dmem_addr_reg <= dmem_addr_next;
            dmem_data_reg <= dmem_data_next;
            start_reg     <= start_next;
            err_reg       <= err_next;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= sum_next;
`endif
        end
    end

    assign imem_we_o   = imem_we_reg;
    assign imem_addr_o = imem_addr_reg;
    assign imem_data_o = imem_data_reg;
    assign dmem_we_o   = dmem_we_reg;
    assign dmem_addr_o = dmem_addr_reg;
    assign dmem_data_o = dmem_data_reg;
    assign start_o     = start_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of header vectors plus hand-timed corner sequences.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready_o;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        dmem_we_o;
    logic [4:0]  dmem_addr_o;
    logic [7:0]  dmem_data_o;
    logic        start_o;
    logic        err_o;

    always #5 clk = ~clk;

    program_loader #(.IADDR_W(8), .DADDR_W(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_data_o (dmem_data_o),
        .start_o     (start_o),
        .err_o       (err_o)
    );

    // Write monitor: records which vector last wrote each location.
    int          vec_id = 0;
    int          iw_total = 0;
    int          dw_total = 0;
    int          both_total = 0;
    int          last_daddr = -1;
    int          imem_tag [256];
    logic [31:0] imem_mem [256];
    int          dmem_tag [32];
    logic [7:0]  dmem_mem [32];

    always @(negedge clk) begin
        if (imem_we_o) begin
            iw_total              <= iw_total + 1;
            imem_tag[imem_addr_o] <= vec_id;
            imem_mem[imem_addr_o] <= imem_data_o;
        end
        if (dmem_we_o) begin
            dw_total              <= dw_total + 1;
            dmem_tag[dmem_addr_o] <= vec_id;
            dmem_mem[dmem_addr_o] <= dmem_data_o;
            last_daddr            <= int'(dmem_addr_o);
        end
        if (imem_we_o && dmem_we_o)
            both_total <= both_total + 1;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Presents a word and returns one time unit after the edge that accepted it.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready_o)
            check("send_ready_timeout", 32'(in_ready_o), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!start_o && !err_o && n < budget) begin
            tick();
            n++;
        end
        if (!start_o && !err_o)
            check("done_timeout", 32'(start_o | err_o), 32'd1);
    endtask

    function automatic logic [31:0] ipay(input int id, input int k);
        return {8'(id), 8'hC3, 16'(k)};
    endfunction

    function automatic logic [31:0] dpay(input int id, input int j);
        return {8'(id), 8'h3C, 16'(j)};
    endfunction

    typedef struct {
        logic [31:0] hdr;
        bit          exp_err;
        int          exp_iw;
        int          exp_dw;
        int          stall;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          iw0, dw0, bad, seen;
        logic [31:0] sum, w;

        vecs[0] = '{32'h0000_0000, 1'b0,   0,  0, 0};
        vecs[1] = '{32'h0101_0000, 1'b1,   0,  0, 0};
        vecs[2] = '{32'h0100_0000, 1'b0, 256,  0, 0};
        vecs[3] = '{32'h0000_0009, 1'b1,   0,  0, 0};
        vecs[4] = '{32'h0000_0008, 1'b0,   0, 32, 0};
        vecs[5] = '{32'h0003_0002, 1'b0,   3,  8, 2};
        vecs[6] = '{32'h0000_4000, 1'b1,   0,  0, 0};
        vecs[7] = '{32'h0002_0003, 1'b0,   2, 12, 1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_imem_we", 32'(imem_we_o), 32'd0);
        check("rst_dmem_we", 32'(dmem_we_o), 32'd0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ready_held", 32'(in_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(in_ready_o), 32'd1);

        // Table-driven header vectors
        for (int i = 0; i < 8; i++) begin
            vec_id = i + 1;
            do_reset();
            iw0 = iw_total;
            dw0 = dw_total;
            sum = 32'd0;
            send_word(vecs[i].hdr);
            if (!vecs[i].exp_err) begin
                for (int k = 0; k < vecs[i].exp_iw; k++) begin
                    sum += ipay(vec_id, k);
                    send_word(ipay(vec_id, k));
                    for (int s = 0; s < vecs[i].stall; s++) tick();
                end
                for (int j = 0; j < vecs[i].exp_dw / 4; j++) begin
                    sum += dpay(vec_id, j);
                    send_word(dpay(vec_id, j));
                    for (int s = 0; s < vecs[i].stall; s++) tick();
                end
`ifdef LOADER_CHECKSUM_EN
                send_word(sum);
`endif
            end
            wait_done(400);
            in_data  = 32'hDEAD_BEEF;
            in_valid = 1'b1;
            for (int s = 0; s < 6; s++) tick();
            in_valid = 1'b0;
            tick();

            check("vec_err", 32'(err_o), 32'(vecs[i].exp_err));
            check("vec_start", 32'(start_o), 32'(!vecs[i].exp_err));
            check("vec_ready", 32'(in_ready_o), 32'd0);
            check("vec_imem_count", 32'(iw_total - iw0), 32'(vecs[i].exp_iw));
            check("vec_dmem_count", 32'(dw_total - dw0), 32'(vecs[i].exp_dw));
            bad = 0;
            for (int k = 0; k < vecs[i].exp_iw; k++)
                if (imem_tag[k] != vec_id || imem_mem[k] !== ipay(vec_id, k)) bad++;
            for (int a = 0; a < vecs[i].exp_dw; a++) begin
                w = dpay(vec_id, a / 4);
                if (dmem_tag[a] != vec_id || dmem_mem[a] !== w[8*(a%4) +: 8]) bad++;
            end
            check("vec_contents", 32'(bad), 32'd0);
            if (vecs[i].exp_dw > 0)
                check("vec_last_daddr", 32'(last_daddr), 32'(vecs[i].exp_dw - 1));
            $display("[TB] vector %0d hdr=0x%08h err=%0b start=%0b imem_writes=%0d dmem_writes=%0d",
                     i, vecs[i].hdr, err_o, start_o, iw_total - iw0, dw_total - dw0);
        end
        check("never_dual_write", 32'(both_total), 32'd0);

        // Example image with exact cycle timing
        vec_id = 20;
        do_reset();
        send_word(32'h0002_0001);
        send_word(32'h2008_0005);
        check("ex_imem0", {7'd0, imem_we_o, imem_addr_o, imem_data_o[15:0]}, {7'd0, 1'b1, 8'd0, 16'h0005});
        send_word(32'h0000_0000);
        check("ex_imem1", {imem_we_o, 23'd0, imem_addr_o}, {1'b1, 23'd0, 8'd1});
        send_word(32'h1122_3344);
        check("ex_drain_quiet", 32'(dmem_we_o | imem_we_o), 32'd0);
        tick();
        check("ex_byte0", {15'd0, dmem_we_o, 3'd0, dmem_addr_o, dmem_data_o}, {15'd0, 1'b1, 3'd0, 5'd0, 8'h44});
        tick();
        check("ex_byte1", {15'd0, dmem_we_o, 3'd0, dmem_addr_o, dmem_data_o}, {15'd0, 1'b1, 3'd0, 5'd1, 8'h33});
        tick();
        check("ex_byte2", {15'd0, dmem_we_o, 3'd0, dmem_addr_o, dmem_data_o}, {15'd0, 1'b1, 3'd0, 5'd2, 8'h22});
        tick();
        check("ex_byte3", {15'd0, dmem_we_o, 3'd0, dmem_addr_o, dmem_data_o}, {15'd0, 1'b1, 3'd0, 5'd3, 8'h11});
        check("ex_start_not_yet", 32'(start_o), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h2008_0005 + 32'h1122_3344);
`endif
        tick();
        check("ex_start", 32'(start_o), 32'd1);
        check("ex_err", 32'(err_o), 32'd0);
        check("ex_imem_word0", imem_mem[0], 32'h2008_0005);
        check("ex_imem_word1", imem_mem[1], 32'h0000_0000);
        $display("[TB] example image loaded start=%0b err=%0b", start_o, err_o);

        // Empty image: start on the second cycle after the header
        do_reset();
        send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0000_0000);
`endif
        check("empty_start_c1", 32'(start_o), 32'd0);
        tick();
        check("empty_start_c2", 32'(start_o), 32'd1);
        $display("[TB] empty image start=%0b", start_o);

        // Oversized NI: sticky error, cleared by reset
        do_reset();
        send_word(32'h0101_0000);
        check("ni_err", 32'(err_o), 32'd1);
        check("ni_err_ready", 32'(in_ready_o), 32'd0);
        seen = 0;
        in_valid = 1'b1;
        for (int s = 0; s < 20; s++) begin
            tick();
            if (start_o || !err_o) seen++;
        end
        in_valid = 1'b0;
        check("ni_err_hold", 32'(seen), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("ni_err_cleared", {31'd0, err_o}, 32'd0);
        check("ni_idle_ready", 32'(in_ready_o), 32'd1);
        $display("[TB] oversized header recovered err=%0b ready=%0b", err_o, in_ready_o);

        // Reset while the third byte is being drained
        vec_id = 30;
        do_reset();
        send_word(32'h0000_0001);
        send_word(32'hA1B2_C3D4);
        tick();
        tick();
        check("mid_byte1", {23'd0, dmem_we_o, 3'd0, dmem_addr_o}, {23'd0, 1'b1, 3'd0, 5'd1});
        rst = 1'b1;
        tick();
        check("mid_rst_dmem_we", 32'(dmem_we_o), 32'd0);
        check("mid_rst_start", 32'(start_o), 32'd0);
        rst = 1'b0;
        #1;
        send_word(32'h0001_0000);
        send_word(32'hCAFE_F00D);
        check("mid_reload_imem", {imem_we_o, 23'd0, imem_addr_o}, {1'b1, 23'd0, 8'd0});
        check("mid_reload_data", imem_data_o, 32'hCAFE_F00D);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hCAFE_F00D);
`endif
        wait_done(20);
        check("mid_reload_start", 32'(start_o), 32'd1);
        $display("[TB] reset mid-drain then reload start=%0b", start_o);

`ifdef LOADER_CHECKSUM_EN
        vec_id = 40;
        do_reset();
        send_word(32'h0001_0000);
        send_word(32'h0000_0010);
        send_word(32'h0000_0010);
        wait_done(20);
        check("ck_good_start", 32'(start_o), 32'd1);
        check("ck_good_err", 32'(err_o), 32'd0);
        $display("[TB] checksum good trailer start=%0b err=%0b", start_o, err_o);

        vec_id = 41;
        do_reset();
        send_word(32'h0001_0000);
        send_word(32'h0000_0010);
        send_word(32'h0000_0011);
        wait_done(20);
        tick();
        check("ck_bad_err", 32'(err_o), 32'd1);
        check("ck_bad_start", 32'(start_o), 32'd0);
        check("ck_bad_imem", imem_mem[0], 32'h0000_0010);
        check("ck_bad_imem_tag", 32'(imem_tag[0]), 32'd41);
        $display("[TB] checksum bad trailer start=%0b err=%0b", start_o, err_o);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
